// File: rtl/vreg_log_pkg.sv
// Shared definitions for the value-change logger: default sizing and the
// layout of a queued change record.
package vreg_log_pkg;

  localparam int DEF_WIDTH     = 56;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_TS_WIDTH  = 32;
  localparam int DEF_OVF_WIDTH = 8;

  // Record layout at default sizing, MSB first: {first, ts, value}.
  typedef struct packed {
    logic                    first;
    logic [DEF_TS_WIDTH-1:0] ts;
    logic [DEF_WIDTH-1:0]    value;
  } vreg_rec_t;

  // Packed width of a record for arbitrary value/timestamp widths.
  function automatic int rec_width(input int value_w, input int ts_w);
    return 1 + ts_w + value_w;
  endfunction

endpackage

// File: rtl/vreg_change_logger_if.sv
// Read port of the change logger: head record plus valid/ready handshake.
interface vreg_change_logger_if
  import vreg_log_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TS_WIDTH = DEF_TS_WIDTH
) ();

  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_value;
  logic [TS_WIDTH-1:0] out_time;
  logic                out_first;

  modport master (
    output out_valid, out_value, out_time, out_first,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_value, out_time, out_first,
    output out_ready
  );

endinterface

// File: rtl/vreg_log_fifo.sv
// Synchronous FIFO with a registered head. The head register is refreshed
// whenever the FIFO stays non-empty and simply holds once it drains, so the
// consumer sees the last popped record rather than a stale slot.
module vreg_log_fifo
  import vreg_log_pkg::*;
#(
  parameter int DATA_W = rec_width(DEF_WIDTH, DEF_TS_WIDTH),
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     cnt;
  logic              pop_ok;
  logic              push_ok;
  logic [AW-1:0]     nxt_rd;
  logic [LW-1:0]     nxt_cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == LW'(DEPTH));
  assign level = cnt;

  // Qualify requests: clear wins, a full FIFO accepts a push only alongside a pop.
  always_comb begin
    pop_ok  = pop && !empty && !clear;
    push_ok = push && !clear && (!full || pop_ok);
    nxt_rd  = rd_ptr + AW'(pop_ok);
    nxt_cnt = cnt + LW'(push_ok) - LW'(pop_ok);
  end

  // Storage array; no reset needed since only occupied slots are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= nxt_rd;
      cnt    <= nxt_cnt;
    end
  end

  // Head register: bypass din when the write lands in the new head slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout <= '0;
    end else if (!clear && nxt_cnt != '0) begin
      dout <= (push_ok && wr_ptr == nxt_rd) ? din : mem[nxt_rd];
    end
  end

endmodule

// File: rtl/vreg_change_logger.sv
// Watches one register, queues {first, timestamp, value} for every change
// (plus a baseline after reset/clear) and counts records lost to a full queue.
module vreg_change_logger
  import vreg_log_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int TS_WIDTH  = DEF_TS_WIDTH,
  parameter int OVF_WIDTH = DEF_OVF_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           watched,
  vreg_change_logger_if.master       rd,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [OVF_WIDTH-1:0]       overflow_count
);

  localparam int REC_W = rec_width(WIDTH, TS_WIDTH);

  logic [TS_WIDTH-1:0]  ts;
  logic [WIDTH-1:0]     prev;
  logic                 baseline_pending;
  logic                 evt;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [REC_W-1:0]     rec_in;
  logic [REC_W-1:0]     rec_out;

  // Change detection; case inequality so X/Z transitions are reported too.
  always_comb begin
    evt    = enable && (baseline_pending || (watched !== prev));
    push   = evt && !clear;
    pop    = rd.out_valid && rd.out_ready && !clear;
    drop   = push && fifo_full && !pop;
    rec_in = {baseline_pending, ts, watched};
  end

  // Timestamp, previous sample and baseline flag advance only while enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts               <= '0;
      prev             <= '0;
      baseline_pending <= 1'b1;
    end else begin
      if (enable) begin
        ts   <= ts + 1'b1;
        prev <= watched;
      end
      if (clear)       baseline_pending <= 1'b1;
      else if (enable) baseline_pending <= 1'b0;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow       <= 1'b0;
      overflow_count <= '0;
    end else if (clear) begin
      overflow       <= 1'b0;
      overflow_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_count != {OVF_WIDTH{1'b1}}) overflow_count <= overflow_count + 1'b1;
    end
  end

  vreg_log_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push),
    .pop     (pop),
    .din     (rec_in),
    .dout    (rec_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign rd.out_valid = !fifo_empty;
  assign rd.out_first = rec_out[REC_W-1];
  assign rd.out_time  = rec_out[WIDTH +: TS_WIDTH];
  assign rd.out_value = rec_out[WIDTH-1:0];

endmodule

// File: tb/tb_vreg_change_logger.sv
// Directed bench for vreg_change_logger at default sizing.
module tb_vreg_change_logger;
  import vreg_log_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        clear;
  logic [55:0] watched;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  overflow_count;

  int n_checks;
  int n_errors;
  logic [31:0] tb_ts;
  logic [31:0] exp_t;

  vreg_change_logger_if #(.WIDTH(56), .TS_WIDTH(32)) rd_if ();

  vreg_change_logger #(
    .WIDTH(56), .DEPTH(8), .TS_WIDTH(32), .OVF_WIDTH(8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .clear          (clear),
    .watched        (watched),
    .rd             (rd_if.master),
    .level          (level),
    .overflow       (overflow),
    .overflow_count (overflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; the bench tracks the DUT timestamp as it goes.
  task automatic step();
    if (enable) tb_ts = tb_ts + 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] t_exp [8];
    n_checks = 0;
    n_errors = 0;
    tb_ts    = 0;
    reset_n  = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    watched  = 56'h234567891200;
    rd_if.out_ready = 1'b0;

    #12;
    chk("rst_valid", rd_if.out_valid, 0);
    chk("rst_value", rd_if.out_value, 0);
    chk("rst_time", rd_if.out_time, 0);
    chk("rst_first", rd_if.out_first, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ovf_cnt", overflow_count, 0);

    @(posedge clk); #1;
    reset_n = 1'b1;

    // baseline record after reset
    step();
    chk("base_level", level, 1);
    chk("base_valid", rd_if.out_valid, 1);
    chk("base_first", rd_if.out_first, 1);
    chk("base_value", rd_if.out_value, 56'h234567891200);
    chk("base_time", rd_if.out_time, 0);
    for (int i = 0; i < 4; i++) step();
    chk("base_level_hold", level, 1);

    // changes at timestamps 5 and 9, then drain
    watched = 56'h1;
    step();
    for (int i = 0; i < 3; i++) step();
    watched = 56'h2;
    step();
    chk("chg_level", level, 3);
    rd_if.out_ready = 1'b1;
    chk("pop0_time", rd_if.out_time, 0);
    chk("pop0_first", rd_if.out_first, 1);
    step();
    chk("pop1_time", rd_if.out_time, 5);
    chk("pop1_value", rd_if.out_value, 1);
    chk("pop1_first", rd_if.out_first, 0);
    step();
    chk("pop2_time", rd_if.out_time, 9);
    chk("pop2_value", rd_if.out_value, 2);
    chk("pop2_first", rd_if.out_first, 0);
    step();
    chk("drain_valid", rd_if.out_valid, 0);
    chk("drain_level", level, 0);
    chk("drain_hold_time", rd_if.out_time, 9);
    chk("drain_hold_value", rd_if.out_value, 2);

    // overflow: restart from reset, toggle for 12 cycles with no consumer
    rd_if.out_ready = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tb_ts = 0;
    for (int k = 0; k < 12; k++) begin
      watched = 56'(k & 1);
      step();
    end
    chk("ovf_level", level, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", overflow_count, 4);
    chk("ovf_head_time", rd_if.out_time, 0);
    chk("ovf_head_first", rd_if.out_first, 1);

    // full FIFO with simultaneous push and pop
    watched = 56'hABC;
    rd_if.out_ready = 1'b1;
    step();
    chk("full_pp_level", level, 8);
    chk("full_pp_count", overflow_count, 4);
    t_exp = '{1, 2, 3, 4, 5, 6, 7, 12};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("full_drain_time%0d", i), rd_if.out_time, t_exp[i]);
      step();
    end
    chk("full_last_value", rd_if.out_value, 56'hABC);
    chk("full_last_first", rd_if.out_first, 0);
    chk("full_drain_valid", rd_if.out_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // clear with queued records and overflow set
    rd_if.out_ready = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      watched = 56'(v);
      step();
    end
    chk("pre_clr_level", level, 3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_level", level, 0);
    chk("clr_valid", rd_if.out_valid, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_ovf_cnt", overflow_count, 0);
    exp_t = tb_ts;
    step();
    chk("clr_base_valid", rd_if.out_valid, 1);
    chk("clr_base_first", rd_if.out_first, 1);
    chk("clr_base_time", rd_if.out_time, 32'd25);
    chk("clr_base_time_model", rd_if.out_time, exp_t);
    chk("clr_base_value", rd_if.out_value, 3);

    // enable low: no detection, timestamp frozen
    enable = 1'b0;
    watched = 56'h4;
    for (int i = 0; i < 3; i++) step();
    chk("dis_level", level, 1);
    enable = 1'b1;
    exp_t = tb_ts;
    rd_if.out_ready = 1'b1;
    step();
    rd_if.out_ready = 1'b0;
    chk("en_level", level, 1);
    chk("en_value", rd_if.out_value, 4);
    chk("en_time", rd_if.out_time, 32'd26);
    chk("en_first", rd_if.out_first, 0);

    // asynchronous reset between edges
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_valid", rd_if.out_valid, 0);
    chk("async_level", level, 0);
    chk("async_time", rd_if.out_time, 0);
    #2;
    reset_n = 1'b1;
    tb_ts = 0;
    step();
    chk("post_rst_first", rd_if.out_first, 1);
    chk("post_rst_time", rd_if.out_time, 0);
    chk("post_rst_value", rd_if.out_value, 4);
    chk("post_rst_level", level, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vreg_change_logger.md
Name: vreg_change_logger

Overview:
- Hardware-side counterpart to the testbench's value-change reporting: samples a watched register every clock, detects changes, and queues {timestamp, value} records.
- The C++ testbench drains the queue through a valid/ready read port, so change history is collected without per-change $display calls.
- Sits in the test harness beside the DUT registers it observes; one instance per watched register.

Parameters:
- WIDTH, 56, bit width of the watched register.
- DEPTH, 8, number of FIFO entries; must be a power of two, at least 2.
- TS_WIDTH, 32, width of the free-running cycle timestamp.
- OVF_WIDTH, 8, width of the saturating dropped-event counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  sampling/timestamp enable.
- clear  in  1  synchronous flush of FIFO, overflow state and baseline.
- watched  in  WIDTH  register being observed.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts head record.
- out_value  out  WIDTH  value of head record.
- out_time  out  TS_WIDTH  timestamp of head record.
- out_first  out  1  head record is the post-reset/post-clear baseline.
- level  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: at least one event was dropped.
- overflow_count  out  OVF_WIDTH  dropped events, saturating at all-ones.

Behaviour:
- Reset (async, reset_n=0): FIFO empty, out_valid=0, out_value=0, out_time=0, out_first=0, level=0, overflow=0, overflow_count=0, timestamp=0, baseline_pending=1, prev=0.
- Timestamp: increments by 1 each cycle enable=1; wraps from all-ones to 0 with no flag.
- Detection, evaluated only when enable=1:
  - If baseline_pending=1, log an event with first=1, then clear baseline_pending.
  - Otherwise, log an event when watched != prev.
  - prev is loaded from watched every enabled cycle.
  - X/Z on watched counts as a change under case inequality (!==).
- Record content: value = watched sampled at cycle N; time = timestamp value at cycle N, before that cycle's increment.
- Latency:
  - Event detected at edge N is written at edge N.
  - out_valid rises after edge N, i.e. visible in cycle N+1 when the FIFO was empty.
  - No combinational fall-through.
- Pop: occurs at a rising edge when out_valid && out_ready. out_* show the next entry afterwards, or hold their last values with out_valid=0.
- out_* are stable while out_valid=1 and out_ready=0.
- Full FIFO:
  - Push with no pop in the same cycle: event dropped, overflow set, overflow_count incremented (saturating).
  - Push and pop in the same cycle: both succeed, level unchanged, no overflow.
- Empty FIFO: out_ready ignored, level stays 0.
- Pointers: log2(DEPTH)-bit read/write pointers plus an occupancy counter; wrap naturally.
- clear=1 (priority over push/pop in the same cycle):
  - FIFO emptied; overflow and overflow_count zeroed.
  - baseline_pending=1; the timestamp is not reset.
  - The first enabled cycle after clear logs a baseline.
- enable=0: no detection, no timestamp increment, prev held; pops still allowed.
- Reset asserted mid-operation: all state returns to reset values immediately; queued records are lost.

Decomposition:
- Shared package vreg_log_pkg:
  - record struct or typedef {first, time, value} and its packed width function.
  - Default parameter constants.
- One sub-module, vreg_log_fifo:
  - Generic synchronous FIFO with push/pop, full/empty, level.
  - Stores the packed record.
- The top level holds detection, the timestamp, baseline and overflow logic.

Test Plan:
- Reset release, enable=1, watched=56'h234567891200 held, out_ready=0 → exactly one record: first=1, value=56'h234567891200, time=0; level=1 thereafter.
- watched changes to 56'h1 at timestamp 5 and to 56'h2 at timestamp 9, then pop all → records (time 0, first=1), (time 5, 56'h1), (time 9, 56'h2), each with first=0 except the first; out_valid drops after the third pop.
- DEPTH=8, out_ready=0, toggle watched every cycle for 12 cycles → level=8, overflow=1, overflow_count=4 (1 baseline + 11 changes, 8 stored); the stored times are 0..7.
- FIFO full, change detected with out_ready=1 in the same cycle → level stays 8, overflow_count unchanged, new record appears last after draining.
- clear pulsed with 3 queued records and overflow set → level=0, overflow=0, count=0; next enabled cycle logs first=1 with the current timestamp (not 0).
- reset_n dropped asynchronously mid-burst between edges → out_valid=0 and level=0 without waiting for an edge; after release, the timestamp restarts at 0 and a baseline is logged.
